// File: rtl/fsm_reto_parametrico.sv
// Challenge-mode game FSM: latches a note sequence, checks decoded keys against the current target note.
// Latency: 1 cycle from datoListo/inicio to every registered output.
// Backpressure: none; keys arriving while not playing, or outside 'a'..'g', are dropped.
module fsm_reto_parametrico #(
    parameter int N_NOTAS     = 10,
    parameter int NOTA_W      = 3,
    parameter int MAX_ERRORES = 3,
    parameter int TIMEOUT     = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              inicio,
    input  logic [N_NOTAS*NOTA_W-1:0]         busNotas,
    input  logic [7:0]                        notaUsuario,
    input  logic                              datoListo,
    output logic [NOTA_W-1:0]                 notaSalida,
    output logic                              juegoListo,
    output logic                              cargarSecuencia,
    output logic                              contarNotas,
    output logic                              finJuego,
    output logic                              gano,
    output logic [$clog2(N_NOTAS+1)-1:0]      puntaje,
    output logic [$clog2(MAX_ERRORES+1)-1:0]  errores
);

    localparam int PW = $clog2(N_NOTAS + 1);
    localparam int EW = $clog2(MAX_ERRORES + 1);
    localparam int IW = $clog2(N_NOTAS);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CARGAR, ESPERAR, FIN} estado_t;

    estado_t           estado, estadoSig;
    logic [IW-1:0]     idx, idxSig;
    logic [TW-1:0]     timer, timerSig;
    logic [PW-1:0]     puntajeSig;
    logic [EW-1:0]     erroresSig;
    logic              ganoSig;
    logic              acierto;
    logic              fallo;
    logic              teclaValida;
    logic [NOTA_W-1:0] codigo;
    logic [NOTA_W-1:0] objetivo;
    logic [NOTA_W-1:0] notaSig;
    logic [NOTA_W-1:0] seq [N_NOTAS];

    assign teclaValida = datoListo && (notaUsuario >= 8'h61) && (notaUsuario <= 8'h67);
    assign codigo      = NOTA_W'(notaUsuario - 8'h60);
    assign objetivo    = seq[idx];

    always_ff @(posedge clk) begin
        if (reset) estado <= IDLE;
        else       estado <= estadoSig;
    end

    always_comb begin
        estadoSig  = estado;
        idxSig     = idx;
        timerSig   = timer;
        puntajeSig = puntaje;
        erroresSig = errores;
        ganoSig    = gano;
        acierto    = 1'b0;
        fallo      = 1'b0;
        case (estado)
            IDLE:    if (inicio) estadoSig = CARGAR;
            CARGAR:  estadoSig = ESPERAR;
            ESPERAR: begin
                // A valid key always takes priority over a timeout in the same cycle.
                if (teclaValida) begin
                    if (codigo == objetivo) begin
                        acierto    = 1'b1;
                        puntajeSig = puntaje + PW'(1);
                        timerSig   = '0;
                        if (idx == IW'(N_NOTAS - 1)) begin
                            estadoSig = FIN;
                            ganoSig   = 1'b1;
                        end else begin
                            idxSig = idx + IW'(1);
                        end
                    end else begin
                        fallo = 1'b1;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    fallo = 1'b1;
                end else begin
                    timerSig = timer + TW'(1);
                end
                if (fallo) begin
                    erroresSig = errores + EW'(1);
                    timerSig   = '0;
                    if (errores == EW'(MAX_ERRORES - 1)) begin
                        estadoSig = FIN;
                        ganoSig   = 1'b0;
                    end
                end
            end
            FIN:     if (inicio) estadoSig = CARGAR;
            default: estadoSig = IDLE;
        endcase
        // Entering CARGAR starts a fresh game.
        if (estadoSig == CARGAR) begin
            idxSig     = '0;
            timerSig   = '0;
            puntajeSig = '0;
            erroresSig = '0;
            ganoSig    = 1'b0;
        end
    end

    always_comb begin
        notaSig = '0;
        if (estadoSig == ESPERAR) begin
            if (estado == CARGAR) notaSig = busNotas[NOTA_W-1:0];
            else                  notaSig = seq[idxSig];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            juegoListo      <= 1'b1;
            cargarSecuencia <= 1'b0;
            contarNotas     <= 1'b0;
            finJuego        <= 1'b0;
            gano            <= 1'b0;
            puntaje         <= '0;
            errores         <= '0;
            notaSalida      <= '0;
            idx             <= '0;
            timer           <= '0;
            for (int i = 0; i < N_NOTAS; i++) seq[i] <= '0;
        end else begin
            juegoListo      <= (estadoSig == IDLE);
            cargarSecuencia <= (estadoSig == CARGAR);
            finJuego        <= (estadoSig == FIN);
            contarNotas     <= acierto;
            gano            <= ganoSig;
            puntaje         <= puntajeSig;
            errores         <= erroresSig;
            notaSalida      <= notaSig;
            idx             <= idxSig;
            timer           <= timerSig;
            if (estado == CARGAR) begin
                for (int i = 0; i < N_NOTAS; i++) seq[i] <= busNotas[i*NOTA_W +: NOTA_W];
            end
        end
    end

endmodule

// File: tb/tb_fsm_reto_parametrico.sv
// Directed bench for fsm_reto_parametrico with a 4-note, 2-error, 16-cycle-timeout configuration.
module tb_fsm_reto_parametrico;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic [11:0] busNotas;
    logic [7:0]  notaUsuario;
    logic        datoListo;
    logic [2:0]  notaSalida;
    logic        juegoListo, cargarSecuencia, contarNotas, finJuego, gano;
    logic [2:0]  puntaje;
    logic [1:0]  errores;

    int total = 0;
    int bad   = 0;

    fsm_reto_parametrico #(
        .N_NOTAS(4), .NOTA_W(3), .MAX_ERRORES(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .busNotas(busNotas),
        .notaUsuario(notaUsuario), .datoListo(datoListo), .notaSalida(notaSalida),
        .juegoListo(juegoListo), .cargarSecuencia(cargarSecuencia), .contarNotas(contarNotas),
        .finJuego(finJuego), .gano(gano), .puntaje(puntaje), .errores(errores)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [7:0] k);
        notaUsuario = k;
        datoListo   = 1'b1;
        tick();
        datoListo   = 1'b0;
        notaUsuario = 8'h00;
    endtask

    initial begin
        logic [7:0] teclas [4];
        logic [2:0] sigNota [4];
        teclas  = '{8'h65, 8'h61, 8'h62, 8'h63};
        sigNota = '{3'd1, 3'd2, 3'd3, 3'd0};

        reset = 1'b1; inicio = 1'b0; busNotas = 12'b011_010_001_101;
        notaUsuario = 8'h00; datoListo = 1'b0;
        tick(); tick();
        chk("rst_juegoListo", juegoListo, 1);
        chk("rst_notaSalida", notaSalida, 0);
        chk("rst_finJuego", finJuego, 0);
        chk("rst_cargar", cargarSecuencia, 0);
        chk("rst_puntaje", puntaje, 0);
        chk("rst_errores", errores, 0);
        chk("rst_gano", gano, 0);
        chk("rst_contar", contarNotas, 0);
        reset = 1'b0;
        tick();
        chk("idle_juegoListo", juegoListo, 1);

        // 1: load
        inicio = 1'b1;
        tick();
        chk("t1_cargar_on", cargarSecuencia, 1);
        chk("t1_juegoListo", juegoListo, 0);
        inicio = 1'b0;
        tick();
        chk("t1_cargar_off", cargarSecuencia, 0);
        chk("t1_nota0", notaSalida, 5);

        // 2: winning run e,a,b,c
        for (int i = 0; i < 4; i++) begin
            key(teclas[i]);
            chk("t2_contar_on", contarNotas, 1);
            chk("t2_puntaje", puntaje, i + 1);
            chk("t2_nota", notaSalida, sigNota[i]);
            tick();
            chk("t2_contar_off", contarNotas, 0);
        end
        chk("t2_fin", finJuego, 1);
        chk("t2_gano", gano, 1);
        chk("t2_errores", errores, 0);
        chk("t2_puntaje_final", puntaje, 4);

        // 3: losing run a,x,a
        inicio = 1'b1;
        tick();
        chk("t3_cargar", cargarSecuencia, 1);
        chk("t3_fin_clear", finJuego, 0);
        chk("t3_puntaje_clear", puntaje, 0);
        inicio = 1'b0;
        tick();
        chk("t3_nota0", notaSalida, 5);
        key(8'h61);
        chk("t3_err1", errores, 1);
        chk("t3_contar", contarNotas, 0);
        chk("t3_nota_retry", notaSalida, 5);
        key(8'h78);
        chk("t3_x_ignored", errores, 1);
        chk("t3_x_nofin", finJuego, 0);
        key(8'h61);
        chk("t3_err2", errores, 2);
        chk("t3_fin", finJuego, 1);
        chk("t3_gano", gano, 0);
        chk("t3_puntaje", puntaje, 0);
        chk("t3_nota_fin", notaSalida, 0);

        // 4: timeout, then key colliding with the next timeout
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        tick();
        chk("t4_err_clear", errores, 0);
        repeat (15) tick();
        chk("t4_pre_timeout", errores, 0);
        tick();
        chk("t4_timeout", errores, 1);
        chk("t4_nota_same", notaSalida, 5);
        repeat (15) tick();
        chk("t4_pre_timeout2", errores, 1);
        key(8'h65);
        chk("t4_key_wins_puntaje", puntaje, 1);
        chk("t4_key_wins_errores", errores, 1);
        chk("t4_contar", contarNotas, 1);
        chk("t4_nota_next", notaSalida, 1);

        // 5: reset mid-game, then inicio held in ESPERAR
        key(8'h61);
        chk("t5_puntaje2", puntaje, 2);
        chk("t5_nota2", notaSalida, 2);
        reset = 1'b1;
        tick();
        chk("t5_rst_juegoListo", juegoListo, 1);
        chk("t5_rst_puntaje", puntaje, 0);
        chk("t5_rst_nota", notaSalida, 0);
        chk("t5_rst_errores", errores, 0);
        reset = 1'b0;
        inicio = 1'b1;
        tick();
        chk("t5_cargar", cargarSecuencia, 1);
        tick();
        chk("t5_cargar_off", cargarSecuencia, 0);
        chk("t5_nota0", notaSalida, 5);
        busNotas = 12'b111_111_111_110;
        repeat (3) tick();
        chk("t5_no_reload_cargar", cargarSecuencia, 0);
        chk("t5_no_reload_nota", notaSalida, 5);
        chk("t5_juegoListo", juegoListo, 0);
        key(8'h65);
        chk("t5_old_seq_puntaje", puntaje, 1);
        chk("t5_old_seq_nota", notaSalida, 1);
        inicio = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
